// File: rtl/game_pkg.sv
// Shared codes for the colour-matching game sequencer.
// Square ids, step codes and small step/colour helpers.
package game_pkg;

  localparam logic [2:0] kare0 = 3'd0;
  localparam logic [2:0] kare1 = 3'd1;
  localparam logic [2:0] kare2 = 3'd2;
  localparam logic [2:0] kare3 = 3'd3;
  localparam logic [2:0] kare4 = 3'd4;
  localparam logic [2:0] kare5 = 3'd5;
  localparam logic [2:0] kare6 = 3'd6;
  localparam logic [2:0] kare7 = 3'd7;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_PREVIEW = 4'd1;
  localparam logic [3:0] S_HIDE    = 4'd2;
  localparam logic [3:0] S_PICK0   = 4'd3;
  localparam logic [3:0] S_PICKN   = 4'd10;
  localparam logic [3:0] S_WIN     = 4'd11;
  localparam logic [3:0] S_LOSE    = 4'd12;

  localparam int TMR_W = 26;

  // steps 3/4 -> pair 0, 5/6 -> 1, 7/8 -> 2, 9/10 -> 3
  function automatic logic [1:0] pair_of(input logic [3:0] step);
    logic [3:0] t;
    t = step - S_PICK0;
    return t[2:1];
  endfunction

  function automatic logic [2:0] color_of(
    input logic [23:0] c,
    input logic [2:0]  sq
  );
    return c[3*sq +: 3];
  endfunction

endpackage

// File: rtl/game_step_ctrl_if.sv
// Handshake/bus bundle between the game sequencer and its
// player-input side and cursor stages.
interface game_step_ctrl_if;
  import game_pkg::*;

  logic        start;
  logic        sel;
  logic [2:0]  cursor;
  logic [23:0] colors;
  logic [3:0]  step_2;
  logic [2:0]  secim1;
  logic [2:0]  secim2;
  logic [2:0]  secim3;
  logic [2:0]  secim4;
  logic [2:0]  es1;
  logic [2:0]  es2;
  logic [2:0]  es3;
  logic [2:0]  es4;
  logic [7:0]  used_mask;
  logic        hold;
  logic [1:0]  misses;
  logic        win;
  logic        lose;

  modport master (
    output start, sel, cursor, colors,
    input  step_2, secim1, secim2, secim3, secim4,
    input  es1, es2, es3, es4,
    input  used_mask, hold, misses, win, lose
  );

  modport slave (
    input  start, sel, cursor, colors,
    output step_2, secim1, secim2, secim3, secim4,
    output es1, es2, es3, es4,
    output used_mask, hold, misses, win, lose
  );

endinterface

// File: rtl/cycle_timer.sv
// Down-counting cycle timer; done pulses in the last
// counted cycle of a loaded interval.
module cycle_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/game_step_ctrl.sv
// Master step sequencer of the 8-square colour-matching game:
// preview, pair picks, mismatch hold/retry, win/lose.
module game_step_ctrl
  import game_pkg::*;
#(
  parameter int PREVIEW_CYCLES = 50_000_000,
  parameter int MISS_HOLD      = 25_000_000,
  parameter int MAX_MISS       = 3
) (
  input logic              clk25MHz,
  input logic              reset,
  game_step_ctrl_if.slave  bus
);

  localparam logic [TMR_W-1:0] PV_LEN = TMR_W'(PREVIEW_CYCLES);
  localparam logic [TMR_W-1:0] MH_LEN = TMR_W'(MISS_HOLD);
  localparam logic [1:0]       MAXM   = 2'(MAX_MISS);

  logic [3:0]      step_q, step_d;
  logic [3:0][2:0] secim_q, secim_d;
  logic [3:0][2:0] es_q, es_d;
  logic [3:0]      sv_q, sv_d;
  logic [3:0]      ev_q, ev_d;
  logic            hold_q, hold_d;
  logic [1:0]      misses_q, misses_d;
  logic            settle_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  logic [7:0] used;
  logic [1:0] k;
  logic       is_idle, is_prev, is_hide;
  logic       is_pick, is_first, is_second;
  logic       accept, same;

  cycle_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk25MHz),
    .rst      (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    used = '0;
    for (int i = 0; i < 4; i++) begin
      if (sv_q[i]) used[secim_q[i]] = 1'b1;
      if (ev_q[i]) used[es_q[i]]    = 1'b1;
    end
  end

  assign k = pair_of(step_q);
  assign is_idle = (step_q == S_IDLE) ||
                   (step_q == S_WIN)  ||
                   (step_q == S_LOSE);
  assign is_prev   = (step_q == S_PREVIEW);
  assign is_hide   = (step_q == S_HIDE);
  assign is_pick   = (step_q >= S_PICK0) &&
                     (step_q <= S_PICKN);
  assign is_first  = is_pick && step_q[0];
  assign is_second = is_pick && !step_q[0];

  // the settle cycle lets the cursor stage reposition
  assign accept = bus.sel && !hold_q && !settle_q &&
                  !used[bus.cursor];
  assign same = color_of(bus.colors, secim_q[k]) ==
                color_of(bus.colors, bus.cursor);

  always_comb begin
    step_d   = step_q;
    secim_d  = secim_q;
    es_d     = es_q;
    sv_d     = sv_q;
    ev_d     = ev_q;
    hold_d   = hold_q;
    misses_d = misses_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (1'b1)
      is_idle: begin
        if (bus.start) begin
          secim_d  = '0;
          es_d     = '0;
          sv_d     = '0;
          ev_d     = '0;
          misses_d = '0;
          hold_d   = 1'b0;
          step_d   = S_PREVIEW;
          tmr_load = 1'b1;
          tmr_val  = PV_LEN;
        end
      end
      is_prev: begin
        if (tmr_done) step_d = S_HIDE;
      end
      is_hide: begin
        step_d = S_PICK0;
      end
      is_first: begin
        if (accept) begin
          secim_d[k] = bus.cursor;
          sv_d[k]    = 1'b1;
          step_d     = step_q + 4'd1;
        end
      end
      is_second: begin
        if (hold_q) begin
          if (tmr_done) begin
            hold_d = 1'b0;
            if (misses_q == MAXM) begin
              step_d = S_LOSE;
            end else begin
              secim_d[k] = '0;
              es_d[k]    = '0;
              sv_d[k]    = 1'b0;
              ev_d[k]    = 1'b0;
              step_d     = step_q - 4'd1;
            end
          end
        end else if (accept) begin
          es_d[k] = bus.cursor;
          ev_d[k] = 1'b1;
          if (same) begin
            step_d = (k == 2'd3) ? S_WIN : step_q + 4'd1;
          end else begin
            hold_d   = 1'b1;
            misses_d = (misses_q == 2'd3) ? 2'd3 :
                       misses_q + 2'd1;
            tmr_load = 1'b1;
            tmr_val  = MH_LEN;
          end
        end
      end
      default: begin
        step_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25MHz or posedge reset) begin
    if (reset) begin
      step_q   <= S_IDLE;
      secim_q  <= '0;
      es_q     <= '0;
      sv_q     <= '0;
      ev_q     <= '0;
      hold_q   <= 1'b0;
      misses_q <= '0;
      settle_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      secim_q  <= secim_d;
      es_q     <= es_d;
      sv_q     <= sv_d;
      ev_q     <= ev_d;
      hold_q   <= hold_d;
      misses_q <= misses_d;
      settle_q <= (step_d != step_q);
    end
  end

  assign bus.step_2    = step_q;
  assign bus.secim1    = sv_q[0] ? secim_q[0] : 3'b000;
  assign bus.secim2    = sv_q[1] ? secim_q[1] : 3'b000;
  assign bus.secim3    = sv_q[2] ? secim_q[2] : 3'b000;
  assign bus.secim4    = sv_q[3] ? secim_q[3] : 3'b000;
  assign bus.es1       = ev_q[0] ? es_q[0] : 3'b000;
  assign bus.es2       = ev_q[1] ? es_q[1] : 3'b000;
  assign bus.es3       = ev_q[2] ? es_q[2] : 3'b000;
  assign bus.es4       = ev_q[3] ? es_q[3] : 3'b000;
  assign bus.used_mask = used;
  assign bus.hold      = hold_q;
  assign bus.misses    = misses_q;
  assign bus.win       = (step_q == S_WIN);
  assign bus.lose      = (step_q == S_LOSE);

endmodule

// File: tb/tb_game_step_ctrl.sv
// Directed bench for game_step_ctrl with short preview
// and hold intervals.
module tb_game_step_ctrl;
  import game_pkg::*;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  game_step_ctrl_if bus();

  game_step_ctrl #(
    .PREVIEW_CYCLES (4),
    .MISS_HOLD      (3),
    .MAX_MISS       (3)
  ) dut (
    .clk25MHz (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [2:0] c);
    bus.cursor = c;
    bus.sel    = 1'b1;
    tick();
    bus.sel    = 1'b0;
  endtask

  // settle cycle, pick a, settle cycle, pick b
  task automatic pair(input logic [2:0] a, input logic [2:0] b);
    tick();
    pick(a);
    tick();
    pick(b);
  endtask

  task automatic to_step3();
    repeat (5) tick();
  endtask

  initial begin
    vecs       = 0;
    errs       = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.sel    = 1'b0;
    bus.cursor = '0;
    // pairs {0,5} {1,6} {2,7} {3,4}
    bus.colors = {3'd3, 3'd2, 3'd1, 3'd4,
                  3'd4, 3'd3, 3'd2, 3'd1};
    repeat (2) tick();
    chk("rst_step", bus.step_2, 0);
    chk("rst_used", bus.used_mask, 0);
    rst = 1'b0;
    tick();

    // run part-way, then abort with reset
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    to_step3();
    tick();
    pick(kare3);
    chk("pre_secim1", bus.secim1, 3);
    chk("pre_used", bus.used_mask, 8'h08);
    rst = 1'b1;
    #2;
    chk("mid_rst_step", bus.step_2, 0);
    chk("mid_rst_secim1", bus.secim1, 0);
    chk("mid_rst_used", bus.used_mask, 0);
    chk("mid_rst_win", {bus.win, bus.lose, bus.hold}, 0);
    tick();
    rst = 1'b0;
    tick();

    // start and sel together in IDLE: start wins
    bus.start  = 1'b1;
    bus.sel    = 1'b1;
    bus.cursor = kare2;
    tick();
    bus.start = 1'b0;
    bus.sel   = 1'b0;
    for (int i = 0; i < 4; i++) chk("preview", bus.step_2, 1);
    chk("start_sel_used", bus.used_mask, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("preview_last", bus.step_2, 1);
    tick();
    chk("hide", bus.step_2, 2);
    tick();
    chk("step3", bus.step_2, 3);

    pair(kare0, kare5);
    chk("p1_secim1", bus.secim1, 0);
    chk("p1_es1", bus.es1, 5);
    chk("p1_used", bus.used_mask, 8'h21);
    chk("p1_step", bus.step_2, 5);

    pick(kare1);
    chk("settle_ign", bus.step_2, 5);
    chk("settle_secim2", bus.secim2, 0);
    pick(kare5);
    chk("used_ign", bus.step_2, 5);
    chk("used_ign_mask", bus.used_mask, 8'h21);

    // mismatch 1
    pick(kare1);
    chk("m1_first", bus.step_2, 6);
    chk("m1_secim2", bus.secim2, 1);
    tick();
    pick(kare2);
    chk("m1_hold", bus.hold, 1);
    chk("m1_miss", bus.misses, 1);
    chk("m1_es2", bus.es2, 2);
    chk("m1_used", bus.used_mask, 8'h27);
    pick(kare6);
    chk("hold_sel_ign", bus.es2, 2);
    tick();
    chk("m1_hold3", {bus.hold, bus.step_2}, 5'h16);
    tick();
    chk("m1_retry", bus.step_2, 5);
    chk("m1_hold_off", bus.hold, 0);
    chk("m1_clr", {bus.secim2, bus.es2}, 0);
    chk("m1_used_clr", bus.used_mask, 8'h21);

    // mismatches 2 and 3
    pair(kare1, kare2);
    repeat (3) tick();
    chk("m2_retry", bus.step_2, 5);
    chk("m2_miss", bus.misses, 2);
    pair(kare1, kare7);
    chk("m3_miss", bus.misses, 3);
    repeat (3) tick();
    chk("lose_step", bus.step_2, 12);
    chk("lose_flag", bus.lose, 1);
    chk("lose_keep", {bus.secim2, bus.es2}, 6'o17);
    chk("lose_used", bus.used_mask, 8'hA3);

    // restart from LOSE
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("re_step", bus.step_2, 1);
    chk("re_miss", bus.misses, 0);
    chk("re_used", bus.used_mask, 0);
    chk("re_lose", bus.lose, 0);
    to_step3();
    chk("re_step3", bus.step_2, 3);

    pair(kare0, kare5);
    pair(kare6, kare1);
    pair(kare2, kare7);
    chk("g_step9", bus.step_2, 9);
    pair(kare4, kare3);
    chk("win_step", bus.step_2, 11);
    chk("win_flag", bus.win, 1);
    chk("win_used", bus.used_mask, 8'hFF);
    chk("win_secim4", {bus.secim4, bus.es4}, 6'o43);
    chk("win_secim2", {bus.secim2, bus.es2}, 6'o61);
    tick();
    pick(kare0);
    chk("win_sel_ign", bus.step_2, 11);
    chk("win_miss", bus.misses, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
